vend_seq: RTL and testbench

VEND_SEQ -- requirements
Module: vend_seq

---
 rtl/vend_pkg.sv | 32 +++
 rtl/vend_edge.sv | 23 ++
 rtl/vend_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_vend_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
package vend_pkg;

    localparam int unsigned COIN_UNIT = 5;
    localparam int unsigned CREDIT_W  = 6;
    // Wide enough for the default handshake timeout of one million cycles.
    localparam int unsigned TMO_W     = 21;
    // One spare bit so a coin sum can be range-checked before it is stored.
    localparam int unsigned SUM_W     = CREDIT_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_ERROR    = 3'd4
    } vend_state_t;

    // Value in credit units of the coin edges seen in one cycle.
    function automatic logic [SUM_W-1:0] coin_value(input logic c5, input logic c10);
        logic [SUM_W-1:0] v;
        v = '0;
        if (c5) begin
            v = v + SUM_W'(COIN_UNIT);
        end
        if (c10) begin
            v = v + SUM_W'(2 * COIN_UNIT);
        end
        return v;
    endfunction

endpackage

// File: rtl/vend_edge.sv
// Rising-edge detector for an already-synchronised level input.
module vend_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_edge_c
);

    logic r_in_q;

    // Delayed copy of the input; reset loads the live level so a held input is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q <= i_in;
        end else begin
            r_in_q <= i_in;
        end
    end

    // Edges are suppressed while reset is asserted.
    assign o_edge_c = i_in & ~r_in_q & ~rst;

endmodule

// File: rtl/vend_seq.sv
// Vending machine sequencer: coin accumulation, dispense and change handshakes, timeout.
module vend_seq
    import vend_pkg::*;
#(
    parameter int unsigned PRICE   = 15,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                vend_done,
    output logic                coin_rej,
    output logic                err
);

    localparam logic [SUM_W-1:0]    PRICE_S    = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C     = CREDIT_W'(COIN_UNIT);
    localparam logic [SUM_W-1:0]    CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [TMO_W-1:0]    TMO_LIM    = TMO_W'(TIMEOUT);

    vend_state_t         r_state;
    vend_state_t         w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic                r_disp_req;
    logic                w_disp_req_nxt;
    logic                r_chg_req;
    logic                w_chg_req_nxt;
    logic                r_vend_done;
    logic                w_vend_done_nxt;
    logic                r_coin_rej;
    logic                w_coin_rej_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic [TMO_W-1:0]    r_tmo;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic                r_disp_ack_q;
    logic                r_chg_ack_q;

    logic                w_c5_edge_c;
    logic                w_c10_edge_c;
    logic                w_cancel_edge_c;
    logic                w_coin_any;
    logic [SUM_W-1:0]    w_sum;
    logic                w_sum_ok;
    logic [SUM_W-1:0]    w_new_credit;
    logic [CREDIT_W-1:0] w_disp_rem;
    logic [CREDIT_W-1:0] w_chg_rem;
    logic                w_in_hs;
    logic                w_hs_req;
    logic                w_hs_ack;
    logic                w_hs_ack_tr;
    logic                w_req_tr;

    vend_edge u_edge_c5 (
        .clk      (clk),
        .rst      (rst),
        .i_in     (coin5),
        .o_edge_c (w_c5_edge_c)
    );

    vend_edge u_edge_c10 (
        .clk      (clk),
        .rst      (rst),
        .i_in     (coin10),
        .o_edge_c (w_c10_edge_c)
    );

    vend_edge u_edge_cancel (
        .clk      (clk),
        .rst      (rst),
        .i_in     (cancel),
        .o_edge_c (w_cancel_edge_c)
    );

    // Coin arithmetic; a sum that cannot be represented is rejected instead of wrapping.
    assign w_coin_any   = w_c5_edge_c | w_c10_edge_c;
    assign w_sum        = {1'b0, r_credit} + coin_value(w_c5_edge_c, w_c10_edge_c);
    assign w_sum_ok     = (w_sum <= CREDIT_MAX);
    assign w_new_credit = (w_coin_any && w_sum_ok) ? w_sum : {1'b0, r_credit};
    assign w_disp_rem   = r_credit - PRICE_C;
    assign w_chg_rem    = r_credit - UNIT_C;

    // The handshake currently owned by the FSM, for timeout supervision.
    assign w_in_hs     = (r_state == ST_DISPENSE) || (r_state == ST_CHANGE);
    assign w_hs_req    = (r_state == ST_DISPENSE) ? r_disp_req : r_chg_req;
    assign w_hs_ack    = (r_state == ST_DISPENSE) ? disp_ack   : chg_ack;
    assign w_hs_ack_tr = (r_state == ST_DISPENSE) ? (disp_ack ^ r_disp_ack_q)
                                                  : (chg_ack ^ r_chg_ack_q);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_credit     <= '0;
            r_disp_req   <= 1'b0;
            r_chg_req    <= 1'b0;
            r_vend_done  <= 1'b0;
            r_coin_rej   <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_tmo        <= '0;
            r_disp_ack_q <= disp_ack;
            r_chg_ack_q  <= chg_ack;
        end else begin
            r_state      <= w_state_nxt;
            r_credit     <= w_credit_nxt;
            r_disp_req   <= w_disp_req_nxt;
            r_chg_req    <= w_chg_req_nxt;
            r_vend_done  <= w_vend_done_nxt;
            r_coin_rej   <= w_coin_rej_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= w_busy_nxt;
            r_tmo        <= w_tmo_nxt;
            r_disp_ack_q <= disp_ack;
            r_chg_ack_q  <= chg_ack;
        end
    end

    // Next-state, credit, handshake and timeout decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_credit_nxt    = r_credit;
        w_disp_req_nxt  = r_disp_req;
        w_chg_req_nxt   = r_chg_req;
        w_vend_done_nxt = 1'b0;
        w_coin_rej_nxt  = 1'b0;
        w_err_nxt       = r_err;
        w_tmo_nxt       = '0;
        w_req_tr        = 1'b0;
        w_busy_nxt      = 1'b0;

        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                w_coin_rej_nxt = w_coin_any && !w_sum_ok;
                w_credit_nxt   = CREDIT_W'(w_new_credit);
                // Cancel wins over dispense: the coin of the same cycle is refunded too.
                if ((r_state == ST_ACCUM) && w_cancel_edge_c) begin
                    w_state_nxt   = ST_CHANGE;
                    w_chg_req_nxt = 1'b1;
                end else if (w_new_credit >= PRICE_S) begin
                    w_state_nxt    = ST_DISPENSE;
                    w_disp_req_nxt = 1'b1;
                end else if (w_new_credit != '0) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DISPENSE: begin
                w_coin_rej_nxt = w_coin_any;
                if (r_disp_req) begin
                    if (disp_ack) begin
                        w_disp_req_nxt = 1'b0;
                    end
                end else if (!disp_ack) begin
                    w_credit_nxt    = w_disp_rem;
                    w_vend_done_nxt = 1'b1;
                    if (w_disp_rem != '0) begin
                        w_state_nxt   = ST_CHANGE;
                        w_chg_req_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_CHANGE: begin
                w_coin_rej_nxt = w_coin_any;
                if (r_chg_req) begin
                    if (chg_ack) begin
                        w_chg_req_nxt = 1'b0;
                    end
                end else if (!chg_ack) begin
                    w_credit_nxt = w_chg_rem;
                    if (w_chg_rem != '0) begin
                        w_chg_req_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_ERROR: begin
                w_coin_rej_nxt = w_coin_any;
                w_disp_req_nxt = 1'b0;
                w_chg_req_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_credit_nxt   = '0;
                w_disp_req_nxt = 1'b0;
                w_chg_req_nxt  = 1'b0;
            end
        endcase

        // Any req/ack movement restarts the wait; a stalled handshake ends in ERROR.
        if (w_in_hs) begin
            w_req_tr = (w_disp_req_nxt != r_disp_req) || (w_chg_req_nxt != r_chg_req);
            if (w_req_tr || w_hs_ack_tr) begin
                w_tmo_nxt = '0;
            end else if (w_hs_req ^ w_hs_ack) begin
                w_tmo_nxt = r_tmo + TMO_W'(1);
                if (w_tmo_nxt >= TMO_LIM) begin
                    w_state_nxt     = ST_ERROR;
                    w_err_nxt       = 1'b1;
                    w_disp_req_nxt  = 1'b0;
                    w_chg_req_nxt   = 1'b0;
                    w_credit_nxt    = r_credit;
                    w_vend_done_nxt = 1'b0;
                    w_tmo_nxt       = '0;
                end
            end
        end

        w_busy_nxt = (w_state_nxt == ST_DISPENSE) || (w_state_nxt == ST_CHANGE) ||
                     (w_state_nxt == ST_ERROR);
    end

    assign credit    = r_credit;
    assign disp_req  = r_disp_req;
    assign chg_req   = r_chg_req;
    assign vend_done = r_vend_done;
    assign coin_rej  = r_coin_rej;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_vend_seq.sv
// Scoreboard bench for vend_seq: stimulus queues expected output events, a monitor checks them.
module tb_vend_seq;

    localparam int unsigned PRICE   = 15;
    localparam int unsigned TIMEOUT = 40;

    localparam int EV_CREDIT = 0;
    localparam int EV_VEND   = 1;
    localparam int EV_REJ    = 2;
    localparam int EV_DISP   = 3;
    localparam int EV_CHG    = 4;
    localparam int EV_ERR    = 5;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       coin5;
    logic       coin10;
    logic       cancel;
    logic       disp_req;
    logic       disp_ack;
    logic       chg_req;
    logic       chg_ack;
    logic [5:0] credit;
    logic       busy;
    logic       vend_done;
    logic       coin_rej;
    logic       err;

    ev_t  exp_q[$];
    int   n_cmp;
    int   n_bad;
    logic mon_en;
    logic resp_en;
    int   resp_dly;

    logic [5:0] prev_credit;
    logic       prev_disp;
    logic       prev_chg;
    logic       prev_err;

    vend_seq #(
        .PRICE   (PRICE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .coin5     (coin5),
        .coin10    (coin10),
        .cancel    (cancel),
        .disp_req  (disp_req),
        .disp_ack  (disp_ack),
        .chg_req   (chg_req),
        .chg_ack   (chg_ack),
        .credit    (credit),
        .busy      (busy),
        .vend_done (vend_done),
        .coin_rej  (coin_rej),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string ev_name(input int k);
        case (k)
            EV_CREDIT: return "credit";
            EV_VEND:   return "vend_done";
            EV_REJ:    return "coin_rej";
            EV_DISP:   return "disp_req_rise";
            EV_CHG:    return "chg_req_rise";
            default:   return "err_rise";
        endcase
    endfunction

    task automatic push(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got %s(%0d), required no event at %0t", ev_name(kind), val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_bad++;
                $display("FAIL event: got %s(%0d), required %s(%0d) at %0t",
                         ev_name(kind), val, ev_name(e.kind), e.val, $time);
            end
        end
    endtask

    // Monitor: turns observable output changes into events and checks them in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (credit != prev_credit) check_ev(EV_CREDIT, int'(credit));
            if (vend_done)             check_ev(EV_VEND, 0);
            if (coin_rej)              check_ev(EV_REJ, 0);
            if (disp_req && !prev_disp) check_ev(EV_DISP, 0);
            if (chg_req && !prev_chg)   check_ev(EV_CHG, 0);
            if (err && !prev_err)       check_ev(EV_ERR, 0);
            n_cmp++;
            if (disp_req && chg_req) begin
                n_bad++;
                $display("FAIL req_excl: got disp_req=1 chg_req=1, required not both at %0t", $time);
            end
        end
        prev_credit = credit;
        prev_disp   = disp_req;
        prev_chg    = chg_req;
        prev_err    = err;
    end

    // Motor / coin-return model answering both handshakes after resp_dly cycles.
    initial begin : responder
        int dcnt;
        int ccnt;
        dcnt     = 0;
        ccnt     = 0;
        disp_ack = 1'b0;
        chg_ack  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (disp_req && !disp_ack) begin
                    if (dcnt >= resp_dly) begin
                        disp_ack = 1'b1;
                        dcnt     = 0;
                    end else begin
                        dcnt++;
                    end
                end else if (!disp_req && disp_ack) begin
                    disp_ack = 1'b0;
                end
                if (chg_req && !chg_ack) begin
                    if (ccnt >= resp_dly) begin
                        chg_ack = 1'b1;
                        ccnt    = 0;
                    end else begin
                        ccnt++;
                    end
                end else if (!chg_req && chg_ack) begin
                    chg_ack = 1'b0;
                end
            end
        end
    end

    task automatic pulse(input logic c5, input logic c10, input logic cn);
        @(posedge clk);
        #1;
        coin5  = c5;
        coin10 = c10;
        cancel = cn;
        repeat (2) @(posedge clk);
        #1;
        coin5  = 1'b0;
        coin10 = 1'b0;
        cancel = 1'b0;
        @(posedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d events outstanding after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        n_cmp    = 0;
        n_bad    = 0;
        mon_en   = 1'b0;
        resp_en  = 1'b1;
        resp_dly = 8;
        rst      = 1'b1;
        coin5    = 1'b0;
        coin10   = 1'b0;
        cancel   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_credit", int'(credit), 0);
        chk("rst_disp_req", int'(disp_req), 0);
        chk("rst_chg_req", int'(chg_req), 0);
        chk("rst_vend_done", int'(vend_done), 0);
        chk("rst_coin_rej", int'(coin_rej), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        mon_en = 1'b1;

        // coin5 then coin10 reaches the price exactly: one vend, no change.
        push(EV_CREDIT, 5);
        pulse(1'b1, 1'b0, 1'b0);
        push(EV_CREDIT, 15);
        push(EV_DISP, 0);
        pulse(1'b0, 1'b1, 1'b0);
        push(EV_CREDIT, 0);
        push(EV_VEND, 0);
        wait_drain("s1_drain", 100);
        settle(20);
        chk("s1_busy", int'(busy), 0);

        // Two coin10: 20 credit, vend, then exactly one coin of change.
        push(EV_CREDIT, 10);
        pulse(1'b0, 1'b1, 1'b0);
        push(EV_CREDIT, 20);
        push(EV_DISP, 0);
        pulse(1'b0, 1'b1, 1'b0);
        push(EV_CREDIT, 5);
        push(EV_VEND, 0);
        push(EV_CHG, 0);
        push(EV_CREDIT, 0);
        wait_drain("s2_drain", 150);
        settle(20);
        chk("s2_busy", int'(busy), 0);

        // Simultaneous coins add 15; cancel while dispensing is ignored.
        push(EV_CREDIT, 15);
        push(EV_DISP, 0);
        pulse(1'b1, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        push(EV_CREDIT, 0);
        push(EV_VEND, 0);
        wait_drain("s3_drain", 100);
        settle(20);
        chk("s3_busy", int'(busy), 0);

        // coin10 then cancel with coin5: full 15 refunded as three coins, no dispense.
        push(EV_CREDIT, 10);
        pulse(1'b0, 1'b1, 1'b0);
        push(EV_CREDIT, 15);
        push(EV_CHG, 0);
        pulse(1'b1, 1'b0, 1'b1);
        push(EV_CREDIT, 10);
        push(EV_CHG, 0);
        push(EV_CREDIT, 5);
        push(EV_CHG, 0);
        push(EV_CREDIT, 0);
        wait_drain("s4_drain", 200);
        settle(20);
        chk("s4_busy", int'(busy), 0);

        // Coin inserted while dispensing is rejected and credit holds.
        push(EV_CREDIT, 10);
        pulse(1'b0, 1'b1, 1'b0);
        push(EV_CREDIT, 15);
        push(EV_DISP, 0);
        pulse(1'b1, 1'b0, 1'b0);
        push(EV_REJ, 0);
        pulse(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("s5_credit_hold", int'(credit), 15);
        chk("s5_busy", int'(busy), 1);
        push(EV_CREDIT, 0);
        push(EV_VEND, 0);
        wait_drain("s5_drain", 100);
        settle(20);

        // Motor never acknowledges: timeout into ERROR, which only reset leaves.
        resp_en = 1'b0;
        push(EV_CREDIT, 10);
        pulse(1'b0, 1'b1, 1'b0);
        push(EV_CREDIT, 15);
        push(EV_DISP, 0);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (TIMEOUT - 5) @(negedge clk);
        chk("s6_err_early", int'(err), 0);
        push(EV_ERR, 0);
        wait_drain("s6_timeout", 60);
        chk("s6_err", int'(err), 1);
        chk("s6_disp_req", int'(disp_req), 0);
        chk("s6_chg_req", int'(chg_req), 0);
        chk("s6_busy", int'(busy), 1);
        chk("s6_credit", int'(credit), 15);
        push(EV_REJ, 0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_drain("s6_rej", 10);
        settle(20);
        chk("s6_err_sticky", int'(err), 1);
        chk("s6_busy_sticky", int'(busy), 1);

        // Reset with coin5 held high: everything clears and the level is not a coin.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        coin5 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_credit", int'(credit), 0);
        chk("rst2_disp_req", int'(disp_req), 0);
        chk("rst2_chg_req", int'(chg_req), 0);
        chk("rst2_vend_done", int'(vend_done), 0);
        chk("rst2_coin_rej", int'(coin_rej), 0);
        chk("rst2_err", int'(err), 0);
        chk("rst2_busy", int'(busy), 0);
        mon_en = 1'b1;
        settle(10);
        chk("rst2_held_level", int'(credit), 0);
        coin5 = 1'b0;
        settle(5);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
